// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Shot sequencer for a battleship-style game. It accepts one shot request at
// a time, presents it to an external scoring datapath for one cycle, registers
// the datapath verdict, reports the result for one cycle, and keeps the
// per-game bookkeeping: shots taken, accumulated hits, a 10x10 map of
// coordinates already fired at, and the remaining big bombs.
//
// Timing: accept edge (IDLE->ISSUE) -> ISSUE->REPORT edge -> ResultValid high.
//
// Configuration macro:
//   GAME_SEQUENCER_BIG_BOMB_EN  defined   : big bombs issued and counted.
//                               undefined : ShotBig ignored, DpBig and
//                                           DpBigLeft tied to 0.
//
// Parameters:
//   MAX_SHOTS   shots allowed per game (1..255)
//   TARGET_HITS accumulated hits that win the game
//   BIG_INIT    big bombs available at game start (0..2)
//
// Ports:
//   clock, reset_L         rising-edge clock, asynchronous active-low reset
//   NewGame                synchronous restart, overrides everything
//   ShotValid/ShotReady    request handshake; ShotX/ShotY/ShotBig payload
//   DpX/DpY/DpBig          shot presented to the scoring datapath
//   DpScoreThis            one-cycle strobe asking the datapath to score
//   DpBigLeft              big bombs remaining
//   DpHit, DpSomethingIsWrong, DpTotalHits, DpBiggestShipHit
//                          datapath verdict, sampled at the end of ISSUE
//   ResultValid/Error/Hit/Biggest
//                          one-cycle result report
//   HitsTotal, ShotsTaken  game counters
//   GameOver, Win          end-of-game status
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned MAX_SHOTS   = 20,
  parameter int unsigned TARGET_HITS = 19,
  parameter int unsigned BIG_INIT    = 2
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       NewGame,
  input  logic       ShotValid,
  input  logic [3:0] ShotX,
  input  logic [3:0] ShotY,
  input  logic       ShotBig,
  output logic       ShotReady,
  output logic [3:0] DpX,
  output logic [3:0] DpY,
  output logic       DpBig,
  output logic       DpScoreThis,
  output logic [1:0] DpBigLeft,
  input  logic       DpHit,
  input  logic       DpSomethingIsWrong,
  input  logic [3:0] DpTotalHits,
  input  logic [4:0] DpBiggestShipHit,
  output logic       ResultValid,
  output logic       ResultError,
  output logic       ResultHit,
  output logic [4:0] ResultBiggest,
  output logic [4:0] HitsTotal,
  output logic [7:0] ShotsTaken,
  output logic       GameOver,
  output logic       Win
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_REPORT,
    S_OVER
  } state_e;

  state_e state_q, state_d;

  logic [3:0]  dp_x_q, dp_y_q;
  logic        dp_score_q;
  logic [4:0]  hits_q;
  logic [7:0]  shots_q;
  logic [99:0] fired_q;
  logic        res_err_q, res_hit_q;
  logic [4:0]  res_biggest_q;

  logic        dp_big;
  logic [1:0]  big_left;

  logic        accept;
  logic        in_range;
  logic [6:0]  map_idx;
  logic        already_fired;
  logic        shot_err;
  logic [5:0]  hits_sum;
  logic [4:0]  hits_sat;
  logic        target_reached;
  logic        game_done;

  // ------------------------------------------------------------------------
  // Shot evaluation, valid only while in ISSUE
  // ------------------------------------------------------------------------
  assign accept   = ShotValid && (state_q == S_IDLE);
  assign in_range = (dp_x_q >= 4'd1) && (dp_x_q <= 4'd10) &&
                    (dp_y_q >= 4'd1) && (dp_y_q <= 4'd10);
  // Row-major index of the 1-based coordinate; forced to 0 when off-board so
  // the map is never addressed past bit 99 (the datapath flags those shots).
  assign map_idx  = in_range ? (7'(dp_y_q - 4'd1) * 7'd10 + 7'(dp_x_q - 4'd1)) : 7'd0;
  assign already_fired = in_range && fired_q[map_idx];
  assign shot_err      = DpSomethingIsWrong || already_fired;

  assign hits_sum = {1'b0, hits_q} + {2'b00, DpTotalHits};
  assign hits_sat = hits_sum[5] ? 5'd31 : hits_sum[4:0];

  assign target_reached = ({27'd0, hits_q} >= TARGET_HITS);
  assign game_done      = target_reached || ({24'd0, shots_q} == MAX_SHOTS);

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ------------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (NewGame) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (accept) state_d = S_ISSUE;
        S_ISSUE:  state_d = S_REPORT;
        S_REPORT: state_d = game_done ? S_OVER : S_IDLE;
        S_OVER:   state_d = S_OVER;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------------
  always_comb begin
    ShotReady     = 1'b0;
    ResultValid   = 1'b0;
    ResultError   = 1'b0;
    ResultHit     = 1'b0;
    ResultBiggest = 5'd0;
    GameOver      = 1'b0;
    Win           = 1'b0;
    unique case (state_q)
      S_IDLE: ShotReady = 1'b1;
      S_REPORT: begin
        ResultValid   = 1'b1;
        ResultError   = res_err_q;
        ResultHit     = res_hit_q;
        ResultBiggest = res_biggest_q;
      end
      S_OVER: begin
        GameOver = 1'b1;
        Win      = target_reached;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------------
  // Shot latch, result capture and game bookkeeping
  // ------------------------------------------------------------------------
  // NOTE: the fired map is game state that NewGame and reset must wipe, so it
  // is a reset flop array rather than a RAM.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      dp_x_q        <= 4'd0;
      dp_y_q        <= 4'd0;
      dp_score_q    <= 1'b0;
      hits_q        <= 5'd0;
      shots_q       <= 8'd0;
      fired_q       <= '0;
      res_err_q     <= 1'b0;
      res_hit_q     <= 1'b0;
      res_biggest_q <= 5'd0;
    end else if (NewGame) begin
      dp_x_q        <= 4'd0;
      dp_y_q        <= 4'd0;
      dp_score_q    <= 1'b0;
      hits_q        <= 5'd0;
      shots_q       <= 8'd0;
      fired_q       <= '0;
      res_err_q     <= 1'b0;
      res_hit_q     <= 1'b0;
      res_biggest_q <= 5'd0;
    end else begin
      // Score strobe is high only for the single ISSUE cycle after an accept.
      dp_score_q <= accept;
      if (accept) begin
        dp_x_q <= ShotX;
        dp_y_q <= ShotY;
      end
      if (state_q == S_ISSUE) begin
        res_err_q     <= shot_err;
        res_hit_q     <= DpHit && !shot_err;
        res_biggest_q <= shot_err ? 5'd0 : DpBiggestShipHit;
        if (!shot_err) begin
          shots_q          <= shots_q + 8'd1;
          hits_q           <= hits_sat;
          fired_q[map_idx] <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Big-bomb handling
  // ------------------------------------------------------------------------
`ifdef GAME_SEQUENCER_BIG_BOMB_EN
  logic       dp_big_q;
  logic [1:0] big_left_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      dp_big_q   <= 1'b0;
      big_left_q <= 2'(BIG_INIT);
    end else if (NewGame) begin
      dp_big_q   <= 1'b0;
      big_left_q <= 2'(BIG_INIT);
    end else begin
      // Issued even with no bombs left; the datapath rejects it as an error.
      dp_big_q <= accept && ShotBig;
      if ((state_q == S_ISSUE) && !shot_err && dp_big_q && (big_left_q != 2'd0))
        big_left_q <= big_left_q - 2'd1;
    end
  end

  assign dp_big   = dp_big_q;
  assign big_left = big_left_q;
`else
  logic unused_shot_big;
  assign unused_shot_big = ShotBig;
  assign dp_big          = 1'b0;
  assign big_left        = 2'b00;
`endif

  assign DpX         = dp_x_q;
  assign DpY         = dp_y_q;
  assign DpBig       = dp_big;
  assign DpScoreThis = dp_score_q;
  assign DpBigLeft   = big_left;
  assign HitsTotal   = hits_q;
  assign ShotsTaken  = shots_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
//
// Two sequencers share the stimulus: u_main with default parameters and
// u_small with MAX_SHOTS=3 / TARGET_HITS=3 for the end-of-game cases. Each has
// its own behavioural scoring datapath holding a fixed board:
//   4-cell ship at y=2, x=2..5  (biggest code 5'b01000)
//   2-cell ship at x=8, y=8..9  (biggest code 5'b00010)
// A big bomb covers the 3x3 area around its center. The datapath flags
// off-board centers and big bombs requested with none left.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

  typedef struct packed {
    logic       hit;
    logic       wrong;
    logic [3:0] total;
    logic [4:0] biggest;
  } dp_resp_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       big;
    logic       exp_dpbig;
    logic       exp_err;
    logic       exp_hit;
    logic [4:0] exp_biggest;
    logic [4:0] exp_hits;
    logic [7:0] exp_shots;
    logic [1:0] exp_left;
  } vec_t;

  logic clock = 1'b0;
  logic reset_L, NewGame, ShotValid, ShotBig;
  logic [3:0] ShotX, ShotY;

  // main DUT signals
  logic       m_ShotReady, m_DpBig, m_DpScoreThis, m_ResultValid, m_ResultError;
  logic       m_ResultHit, m_GameOver, m_Win;
  logic [3:0] m_DpX, m_DpY;
  logic [1:0] m_DpBigLeft;
  logic [4:0] m_ResultBiggest, m_HitsTotal;
  logic [7:0] m_ShotsTaken;
  dp_resp_t   m_resp;

  // small DUT signals
  logic       s_ShotReady, s_DpBig, s_DpScoreThis, s_ResultValid, s_ResultError;
  logic       s_ResultHit, s_GameOver, s_Win;
  logic [3:0] s_DpX, s_DpY;
  logic [1:0] s_DpBigLeft;
  logic [4:0] s_ResultBiggest, s_HitsTotal;
  logic [7:0] s_ShotsTaken;
  dp_resp_t   s_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  function automatic dp_resp_t dp_model(input logic [3:0] x, input logic [3:0] y,
                                        input logic big, input logic [1:0] left);
    dp_resp_t r;
    int cx, cy, cnt;
    logic s4, s2;
    cnt = 0;
    s4  = 1'b0;
    s2  = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (big || (dx == 0 && dy == 0)) begin
          cx = int'(x) + dx;
          cy = int'(y) + dy;
          if (cy == 2 && cx >= 2 && cx <= 5) begin
            cnt++;
            s4 = 1'b1;
          end else if (cx == 8 && (cy == 8 || cy == 9)) begin
            cnt++;
            s2 = 1'b1;
          end
        end
      end
    end
    r.total   = 4'(cnt);
    r.hit     = (cnt != 0);
    r.biggest = s4 ? 5'b01000 : (s2 ? 5'b00010 : 5'b00000);
    r.wrong   = (x < 4'd1) || (x > 4'd10) || (y < 4'd1) || (y > 4'd10) ||
                (big && left == 2'd0);
    return r;
  endfunction

  always_comb m_resp = dp_model(m_DpX, m_DpY, m_DpBig, m_DpBigLeft);
  always_comb s_resp = dp_model(s_DpX, s_DpY, s_DpBig, s_DpBigLeft);

  game_sequencer u_main (
    .clock(clock), .reset_L(reset_L), .NewGame(NewGame),
    .ShotValid(ShotValid), .ShotX(ShotX), .ShotY(ShotY), .ShotBig(ShotBig),
    .ShotReady(m_ShotReady), .DpX(m_DpX), .DpY(m_DpY), .DpBig(m_DpBig),
    .DpScoreThis(m_DpScoreThis), .DpBigLeft(m_DpBigLeft),
    .DpHit(m_resp.hit), .DpSomethingIsWrong(m_resp.wrong),
    .DpTotalHits(m_resp.total), .DpBiggestShipHit(m_resp.biggest),
    .ResultValid(m_ResultValid), .ResultError(m_ResultError),
    .ResultHit(m_ResultHit), .ResultBiggest(m_ResultBiggest),
    .HitsTotal(m_HitsTotal), .ShotsTaken(m_ShotsTaken),
    .GameOver(m_GameOver), .Win(m_Win)
  );

  game_sequencer #(.MAX_SHOTS(3), .TARGET_HITS(3), .BIG_INIT(2)) u_small (
    .clock(clock), .reset_L(reset_L), .NewGame(NewGame),
    .ShotValid(ShotValid), .ShotX(ShotX), .ShotY(ShotY), .ShotBig(ShotBig),
    .ShotReady(s_ShotReady), .DpX(s_DpX), .DpY(s_DpY), .DpBig(s_DpBig),
    .DpScoreThis(s_DpScoreThis), .DpBigLeft(s_DpBigLeft),
    .DpHit(s_resp.hit), .DpSomethingIsWrong(s_resp.wrong),
    .DpTotalHits(s_resp.total), .DpBiggestShipHit(s_resp.biggest),
    .ResultValid(s_ResultValid), .ResultError(s_ResultError),
    .ResultHit(s_ResultHit), .ResultBiggest(s_ResultBiggest),
    .HitsTotal(s_HitsTotal), .ShotsTaken(s_ShotsTaken),
    .GameOver(s_GameOver), .Win(s_Win)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge with u_main in IDLE; returns one cycle after
  // REPORT. Checks the 2-cycle latency and the ISSUE presentation.
  task automatic do_shot(input logic [3:0] x, input logic [3:0] y, input logic big,
                         output logic dpbig, output logic err, output logic hit,
                         output logic [4:0] biggest);
    ShotValid = 1'b1;
    ShotX     = x;
    ShotY     = y;
    ShotBig   = big;
    #1 check("ready_idle", m_ShotReady, 1);
    @(posedge clock);
    #1 ShotValid = 1'b0;
    ShotBig = 1'b0;
    @(negedge clock);
    check("issue_score", m_DpScoreThis, 1);
    check("issue_x", m_DpX, x);
    check("issue_y", m_DpY, y);
    check("issue_ready", m_ShotReady, 0);
    check("issue_no_valid", m_ResultValid, 0);
    dpbig = m_DpBig;
    @(negedge clock);
    check("latency_valid", m_ResultValid, 1);
    check("report_score", m_DpScoreThis, 0);
    err     = m_ResultError;
    hit     = m_ResultHit;
    biggest = m_ResultBiggest;
    @(negedge clock);
  endtask

  task automatic new_game_pulse();
    NewGame = 1'b1;
    @(posedge clock);
    #1 NewGame = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    logic [1:0] init_left;
    logic dpbig, err, hit;
    logic [4:0] biggest;

`ifdef GAME_SEQUENCER_BIG_BOMB_EN
    init_left = 2'd2;
    vecs[3] = '{4'd3,  4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'b01000, 5'd4, 8'd3, 2'd1};
    vecs[4] = '{4'd0,  4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'd4, 8'd3, 2'd1};
    vecs[5] = '{4'd11, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'd4, 8'd3, 2'd1};
    vecs[6] = '{4'd8,  4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00010, 5'd6, 8'd4, 2'd0};
    vecs[7] = '{4'd5,  4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd6, 8'd4, 2'd0};
`else
    init_left = 2'd0;
    vecs[3] = '{4'd3,  4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01000, 5'd2, 8'd3, 2'd0};
    vecs[4] = '{4'd0,  4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'd2, 8'd3, 2'd0};
    vecs[5] = '{4'd11, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'd2, 8'd3, 2'd0};
    vecs[6] = '{4'd8,  4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 5'd3, 8'd4, 2'd0};
    vecs[7] = '{4'd5,  4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'd3, 8'd5, 2'd0};
`endif
    vecs[0] = '{4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01000, 5'd1, 8'd1, init_left};
    vecs[1] = '{4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'd1, 8'd2, init_left};
    vecs[2] = '{4'd2, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'd1, 8'd2, init_left};

    // ---- reset ----
    reset_L = 1'b0; NewGame = 1'b0; ShotValid = 1'b0; ShotBig = 1'b0;
    ShotX = 4'd0; ShotY = 4'd0;
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    #1;
    check("rst_ready", m_ShotReady, 1);
    check("rst_hits", m_HitsTotal, 0);
    check("rst_shots", m_ShotsTaken, 0);
    check("rst_valid", m_ResultValid, 0);
    check("rst_over", m_GameOver, 0);
    check("rst_win", m_Win, 0);
    check("rst_score", m_DpScoreThis, 0);
    check("rst_dpx", m_DpX, 0);
    check("rst_bigleft", m_DpBigLeft, init_left);
    @(negedge clock);

    // ---- three misses on the MAX_SHOTS=3 instance ----
    do_shot(4'd1, 4'd1, 1'b0, dpbig, err, hit, biggest);
    do_shot(4'd1, 4'd2, 1'b0, dpbig, err, hit, biggest);
    do_shot(4'd1, 4'd3, 1'b0, dpbig, err, hit, biggest);
    check("miss_hit", hit, 0);
    check("miss_err", err, 0);
    check("small_over", s_GameOver, 1);
    check("small_nowin", s_Win, 0);
    check("small_shots", s_ShotsTaken, 3);
    check("main_not_over", m_GameOver, 0);
    ShotValid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("over_ready", s_ShotReady, 0);
      check("over_stays", s_GameOver, 1);
      check("over_no_issue", s_DpScoreThis, 0);
    end
    ShotValid = 1'b0;
    new_game_pulse();
    check("ng_ready", s_ShotReady, 1);
    check("ng_over", s_GameOver, 0);
    check("ng_shots", s_ShotsTaken, 0);
    check("ng_main_shots", m_ShotsTaken, 0);

    // ---- table-driven shots on the default instance ----
    for (int i = 0; i < 8; i++) begin
      do_shot(vecs[i].x, vecs[i].y, vecs[i].big, dpbig, err, hit, biggest);
      check($sformatf("v%0d dpbig", i), dpbig, vecs[i].exp_dpbig);
      check($sformatf("v%0d err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d hit", i), hit, vecs[i].exp_hit);
      check($sformatf("v%0d biggest", i), biggest, vecs[i].exp_biggest);
      check($sformatf("v%0d hits", i), m_HitsTotal, vecs[i].exp_hits);
      check($sformatf("v%0d shots", i), m_ShotsTaken, vecs[i].exp_shots);
      check($sformatf("v%0d bigleft", i), m_DpBigLeft, vecs[i].exp_left);
      check($sformatf("v%0d idle_score", i), m_DpScoreThis, 0);
      check($sformatf("v%0d idle_dpbig", i), m_DpBig, 0);
      check($sformatf("v%0d hold_x", i), m_DpX, vecs[i].x);
      check($sformatf("v%0d idle_valid", i), m_ResultValid, 0);
      check($sformatf("v%0d idle_ready", i), m_ShotReady, 1);
    end

    // ---- win on the TARGET_HITS=3 instance ----
    new_game_pulse();
    check("ng_bigleft", m_DpBigLeft, init_left);
    check("ng_hits", m_HitsTotal, 0);
    do_shot(4'd2, 4'd2, 1'b0, dpbig, err, hit, biggest);
    do_shot(4'd3, 4'd2, 1'b0, dpbig, err, hit, biggest);
    do_shot(4'd4, 4'd2, 1'b0, dpbig, err, hit, biggest);
    check("win_over", s_GameOver, 1);
    check("win_win", s_Win, 1);
    check("win_hits", s_HitsTotal, 3);
    check("win_main_hits", m_HitsTotal, 3);
    check("win_main_nowin", m_Win, 0);

    // ---- NewGame during ISSUE drops the shot ----
    new_game_pulse();
    ShotValid = 1'b1; ShotX = 4'd2; ShotY = 4'd2;
    @(posedge clock);
    #1 ShotValid = 1'b0;
    NewGame = 1'b1;
    @(negedge clock);
    check("ngi_issue", m_DpScoreThis, 1);
    @(posedge clock);
    #1 NewGame = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("ngi_no_valid", m_ResultValid, 0);
    end
    check("ngi_shots", m_ShotsTaken, 0);
    check("ngi_ready", m_ShotReady, 1);

    // ---- NewGame during REPORT ----
    ShotValid = 1'b1; ShotX = 4'd2; ShotY = 4'd2;
    @(posedge clock);
    #1 ShotValid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("ngr_valid", m_ResultValid, 1);
    check("ngr_hits", m_HitsTotal, 1);
    new_game_pulse();
    check("ngr_idle_valid", m_ResultValid, 0);
    check("ngr_cleared_hits", m_HitsTotal, 0);
    check("ngr_cleared_shots", m_ShotsTaken, 0);
    check("ngr_ready", m_ShotReady, 1);

    // ---- asynchronous reset during ISSUE ----
    do_shot(4'd8, 4'd9, 1'b0, dpbig, err, hit, biggest);
    check("pre_rst_hits", m_HitsTotal, 1);
    ShotValid = 1'b1; ShotX = 4'd3; ShotY = 4'd7;
    @(posedge clock);
    #1 ShotValid = 1'b0;
    @(negedge clock);
    check("ari_issue", m_DpScoreThis, 1);
    reset_L = 1'b0;
    #1;
    check("ari_score", m_DpScoreThis, 0);
    check("ari_dpx", m_DpX, 0);
    check("ari_dpy", m_DpY, 0);
    check("ari_hits", m_HitsTotal, 0);
    check("ari_shots", m_ShotsTaken, 0);
    check("ari_ready", m_ShotReady, 1);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("ari_no_valid", m_ResultValid, 0);
    end
    check("ari_bigleft", m_DpBigLeft, init_left);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MAX_SHOTS, default 20, meaning shots allowed per game (1..255).
REQ-002 SHALL have parameter TARGET_HITS, default 19, meaning accumulated hits that win the game.
REQ-003 SHALL have parameter BIG_INIT, default 2, meaning big bombs at game start (0..2).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clock  input  1  rising-edge clock.
REQ-005 SHALL have reset_L  input  1  asynchronous active-low reset.
REQ-006 SHALL have NewGame  input  1  synchronous restart pulse.
REQ-007 SHALL have ShotValid  input  1  shot request; ShotX, ShotY  input  4 each  requested coordinate; ShotBig  input  1  big-bomb request.
REQ-008 SHALL have ShotReady  output  1  request accepted when ShotValid & ShotReady.
REQ-009 SHALL have DpX, DpY  output  4 each; DpBig, DpScoreThis  output  1 each; DpBigLeft  output  2; these drive the scoring datapath.
REQ-010 SHALL have DpHit, DpSomethingIsWrong  input  1 each; DpTotalHits  input  4; DpBiggestShipHit  input  5; these are datapath results.
REQ-011 SHALL have ResultValid, ResultError, ResultHit  output  1 each; ResultBiggest  output  5; HitsTotal  output  5; ShotsTaken  output  8; GameOver, Win  output  1 each.

Function
REQ-012 SHALL implement states IDLE, ISSUE, REPORT and OVER.
REQ-013 In IDLE, ShotReady SHALL be 1; an accepted request SHALL latch ShotX/ShotY/ShotBig and move to ISSUE at the next edge.
REQ-014 ShotReady SHALL be 0 in ISSUE, REPORT and OVER; ShotValid SHALL be ignored there.
REQ-015 In ISSUE, the block SHALL drive DpX/DpY with the latched coordinate, DpBig with the latched big flag, and DpScoreThis=1, for exactly one cycle.
REQ-016 In all other states, DpScoreThis SHALL be 0, DpBig SHALL be 0, and DpX/DpY SHALL hold their last value.
REQ-017 DpBigLeft SHALL always equal the internal big-bombs-remaining counter.
REQ-018 At the ISSUE->REPORT edge, the block SHALL register the datapath results.
REQ-019 A shot SHALL be erroneous if DpSomethingIsWrong=1 or the coordinate is already marked in the fired map.
REQ-020 For a non-erroneous shot at the ISSUE->REPORT edge, the block SHALL:
- increment ShotsTaken;
- add DpTotalHits to HitsTotal, saturating at 31;
- decrement the big counter if the shot was big;
- set the fired-map bit for the center coordinate.
REQ-021 For an erroneous shot, counters and the fired map SHALL be unchanged.
REQ-022 The fired map SHALL be 10x10 and cover coordinates 1..10; a big shot SHALL mark only its center.
REQ-023 In REPORT, for one cycle, the block SHALL drive ResultValid=1, ResultError, ResultHit=DpHit&!error and ResultBiggest (0 if error).
REQ-024 REPORT SHALL go to OVER if HitsTotal>=TARGET_HITS or ShotsTaken==MAX_SHOTS, and SHALL go to IDLE otherwise.
REQ-025 Total latency SHALL be 2 cycles, from the accept edge to ResultValid high.
REQ-026 In OVER, GameOver SHALL be 1, and Win SHALL be 1 if HitsTotal>=TARGET_HITS.
REQ-027 The block SHALL remain in OVER until NewGame.
REQ-028 A big request with the counter at 0 SHALL still be issued with DpBig=1, so that the datapath flags it and the shot is reported as an error.
REQ-029 NewGame SHALL take priority in any state, with the same effect as reset except that it is synchronous; a mid-shot NewGame SHALL drop that shot without a ResultValid.

Reset
REQ-030 On reset_L=0, the block SHALL asynchronously enter IDLE and clear all of the following to 0:
- HitsTotal, ShotsTaken, the fired map;
- ResultValid, ResultError, ResultHit, ResultBiggest;
- GameOver, Win;
- DpX, DpY, DpBig, DpScoreThis.
REQ-031 On reset, the big counter SHALL load BIG_INIT.
REQ-032 ShotReady SHALL be 1 in the first cycle after reset_L deasserts.

Configuration
REQ-033 With macro GAME_SEQUENCER_BIG_BOMB_EN defined, big-bomb behaviour SHALL be as above.
REQ-034 Without GAME_SEQUENCER_BIG_BOMB_EN, ShotBig SHALL be ignored, DpBig SHALL be constant 0, and the big counter and DpBigLeft SHALL be constant 2'b00 (no big logic synthesized).

Verification (bench instantiates the real scoring datapath)
REQ-035 Reset, then a shot at (2,2), normal -> ResultValid 2 cycles after accept; ResultHit=1; ResultBiggest=5'b01000; HitsTotal=1; ShotsTaken=1.
REQ-036 A shot at (1,1), then (2,2) again -> first shot: ResultHit=0, ResultError=0; repeat shot: ResultError=1, with HitsTotal and ShotsTaken unchanged.
REQ-037 Big shot at (3,2) -> HitsTotal increases by DpTotalHits, and DpBigLeft goes 2->1; two further big shots -> the third is reported with ResultError=1 and DpBigLeft stays 0.
REQ-038 Shot at (0,5) or (11,3) -> ResultError=1, with no counter change.
REQ-039 MAX_SHOTS=3 with three valid misses -> GameOver=1 and Win=0 after the third REPORT; ShotValid held high gets ShotReady=0; NewGame -> IDLE with all counters cleared.
REQ-040 reset_L asserted during ISSUE -> all outputs cleared immediately, with no ResultValid; NewGame in REPORT -> IDLE next cycle with counters cleared.
